// File: rtl/uart_cmd_sequencer_if.sv
// Handshake bundle between the command sequencer and its payload FIFO,
// UART transmitter/receiver and result FIFO.
interface uart_cmd_sequencer_if;
    logic       start;
    logic [7:0] pay_len;
    logic [7:0] pay_byte;
    logic       pay_empty;
    logic       pay_valid;
    logic       pay_rd_en;
    logic [7:0] tx_byte;
    logic       tx_en;
    logic       tx_busy;
    logic [7:0] rx_byte;
    logic       rx_ready;
    logic [7:0] res_byte;
    logic       res_wr_en;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        input  start, pay_len, pay_byte, pay_empty, pay_valid,
        input  tx_busy, rx_byte, rx_ready,
        output pay_rd_en, tx_byte, tx_en, res_byte, res_wr_en,
        output busy, done, err
    );

    modport slave (
        output start, pay_len, pay_byte, pay_empty, pay_valid,
        output tx_busy, rx_byte, rx_ready,
        input  pay_rd_en, tx_byte, tx_en, res_byte, res_wr_en,
        input  busy, done, err
    );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// Host-side UART command initiator: frames FF, payload, FE, 7F, 7E to the
// transmitter, then gathers the readback bytes into the result FIFO.
module uart_cmd_sequencer #(
    parameter int WRITE_WAIT = 4096,
    parameter int RX_TIMEOUT = 1000000,
    parameter int CNT_W      = 20
) (
    input  logic                  clk_100,
    input  logic                  Reset_n,
    uart_cmd_sequencer_if.master  cmd
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEND_START,
        S_FETCH,
        S_WAIT_DATA,
        S_SEND_DATA,
        S_SEND_STOP,
        S_SEND_WRITE,
        S_WAIT_WR,
        S_SEND_XMIT,
        S_COLLECT,
        S_DONE,
        S_TX_WAIT
    } state_e;

    localparam logic [CNT_W-1:0] WW_LAST = CNT_W'(WRITE_WAIT - 1);
    localparam logic [CNT_W-1:0] RT_LAST = CNT_W'(RX_TIMEOUT - 1);

    state_e           state_q;
    state_e           ret_q;
    logic [7:0]       len_q;
    logic [7:0]       plen_q;
    logic [7:0]       rcnt_q;
    logic [7:0]       data_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       wcnt_q;
    logic             abort_q;
    logic [7:0]       tx_byte_q;
    logic             tx_en_q;
    logic             pay_rd_en_q;
    logic [7:0]       res_byte_q;
    logic             res_wr_en_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic             snd_req_d;
    logic [7:0]       snd_byte_d;
    state_e           snd_ret_d;
    logic             data_bad;
    logic             tx_go;

    assign data_bad = (data_q == 8'hFE) || (data_q == 8'hFF);
    assign tx_go    = snd_req_d && !cmd.tx_busy;

    // Which byte each SEND state launches and where it resumes afterwards
    always_comb begin
        snd_req_d  = 1'b0;
        snd_byte_d = 8'h00;
        snd_ret_d  = S_IDLE;
        unique case (state_q)
            S_SEND_START: begin
                snd_req_d  = 1'b1;
                snd_byte_d = 8'hFF;
                snd_ret_d  = (len_q != 8'd0) ? S_FETCH : S_SEND_STOP;
            end
            S_SEND_DATA: begin
                snd_req_d  = !data_bad;
                snd_byte_d = data_q;
                snd_ret_d  = (len_q > 8'd1) ? S_FETCH : S_SEND_STOP;
            end
            S_SEND_STOP: begin
                snd_req_d  = 1'b1;
                snd_byte_d = 8'hFE;
                snd_ret_d  = abort_q ? S_DONE : S_SEND_WRITE;
            end
            S_SEND_WRITE: begin
                snd_req_d  = 1'b1;
                snd_byte_d = 8'h7F;
                snd_ret_d  = S_WAIT_WR;
            end
            S_SEND_XMIT: begin
                snd_req_d  = 1'b1;
                snd_byte_d = 8'h7E;
                snd_ret_d  = S_COLLECT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_100 or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            ret_q       <= S_IDLE;
            len_q       <= 8'd0;
            plen_q      <= 8'd0;
            rcnt_q      <= 8'd0;
            data_q      <= 8'd0;
            cnt_q       <= '0;
            wcnt_q      <= 2'd0;
            abort_q     <= 1'b0;
            tx_byte_q   <= 8'd0;
            tx_en_q     <= 1'b0;
            pay_rd_en_q <= 1'b0;
            res_byte_q  <= 8'd0;
            res_wr_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            tx_en_q     <= 1'b0;
            pay_rd_en_q <= 1'b0;
            res_wr_en_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd.start && !cmd.tx_busy) begin
                        len_q   <= cmd.pay_len;
                        plen_q  <= cmd.pay_len;
                        err_q   <= 1'b0;
                        abort_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_SEND_START;
                    end
                end
                S_FETCH: begin
                    if (!cmd.pay_empty) begin
                        pay_rd_en_q <= 1'b1;
                        state_q     <= S_WAIT_DATA;
                    end
                end
                S_WAIT_DATA: begin
                    if (cmd.pay_valid) begin
                        data_q  <= cmd.pay_byte;
                        state_q <= S_SEND_DATA;
                    end
                end
                S_SEND_DATA: begin
                    // A framing byte inside the payload would desync the responder
                    if (data_bad) begin
                        abort_q <= 1'b1;
                        state_q <= S_SEND_STOP;
                    end else if (tx_go && len_q != 8'd0) begin
                        len_q <= len_q - 8'd1;
                    end
                end
                S_SEND_WRITE: begin
                    if (tx_go) cnt_q <= '0;
                end
                S_WAIT_WR: begin
                    if (cnt_q == WW_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_SEND_XMIT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_SEND_XMIT: begin
                    if (tx_go) begin
                        rcnt_q <= plen_q;
                        cnt_q  <= '0;
                    end
                end
                S_COLLECT: begin
                    if (rcnt_q == 8'd0) begin
                        state_q <= S_DONE;
                    end else if (cmd.rx_ready) begin
                        res_byte_q  <= cmd.rx_byte;
                        res_wr_en_q <= 1'b1;
                        rcnt_q      <= rcnt_q - 8'd1;
                        cnt_q       <= '0;
                        if (rcnt_q == 8'd1) state_q <= S_DONE;
                    end else if (cnt_q == RT_LAST) begin
                        abort_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    err_q   <= abort_q;
                    state_q <= S_IDLE;
                end
                S_TX_WAIT: begin
                    // Transmitter raises busy a cycle late; skip two cycles first
                    if (wcnt_q != 2'd2) begin
                        wcnt_q <= wcnt_q + 2'd1;
                    end else if (!cmd.tx_busy) begin
                        state_q <= ret_q;
                    end
                end
                default: ;
            endcase
            if (tx_go) begin
                tx_byte_q <= snd_byte_d;
                tx_en_q   <= 1'b1;
                ret_q     <= snd_ret_d;
                wcnt_q    <= 2'd0;
                state_q   <= S_TX_WAIT;
            end
        end
    end

    assign cmd.tx_byte   = tx_byte_q;
    assign cmd.tx_en     = tx_en_q;
    assign cmd.pay_rd_en = pay_rd_en_q;
    assign cmd.res_byte  = res_byte_q;
    assign cmd.res_wr_en = res_wr_en_q;
    assign cmd.busy      = busy_q;
    assign cmd.done      = done_q;
    assign cmd.err       = err_q;

endmodule
